// File: rtl/mm_copro_ctrl.sv
// Execution controller for the sparse x dense matrix-multiply coprocessor.
// Runs LOAD_DENSE / LOAD_SPARSE / RESET_ACC / STORE_ACC one at a time and drives the result port.
module mm_copro_ctrl #(
    parameter int XLEN        = 32,
    parameter int DENSE_DEPTH = 16,
    parameter int ID_WIDTH    = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [1:0]           issue_op_i,
    input  logic [ID_WIDTH-1:0]  issue_id_i,
    input  logic [4:0]           issue_rd_i,
    input  logic [XLEN-1:0]      issue_rs1_i,
    input  logic [XLEN-1:0]      issue_rs2_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [ID_WIDTH-1:0]  result_id_o,
    output logic [4:0]           result_rd_o,
    output logic [XLEN-1:0]      result_data_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] mac_count_o,
    output logic                 oob_err_o
);
    localparam int IDXW = $clog2(DENSE_DEPTH);

    localparam logic [1:0] OP_LOAD_DENSE  = 2'b00;
    localparam logic [1:0] OP_LOAD_SPARSE = 2'b01;
    localparam logic [1:0] OP_RESET_ACC   = 2'b10;
    localparam logic [1:0] OP_STORE_ACC   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [XLEN-1:0]       r_dense [DENSE_DEPTH];
    logic [XLEN-1:0]       r_acc;
    logic [XLEN-1:0]       r_prod;
    logic                  r_prod_live;
    logic [CNT_WIDTH-1:0]  r_mac_count;
    logic                  r_oob;
    logic                  r_res_valid;
    logic [ID_WIDTH-1:0]   r_res_id;
    logic [4:0]            r_res_rd;
    logic [XLEN-1:0]       r_res_data;

    logic                  w_accept;
    logic [IDXW-1:0]       w_idx;
    logic                  w_oob;
    logic [XLEN-1:0]       w_prod;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign issue_ready_o  = (r_state == S_IDLE);
    assign busy_o         = (r_state != S_IDLE);
    assign w_accept       = issue_valid_i & issue_ready_o;
    assign w_idx          = issue_rs2_i[IDXW-1:0];
    // Any index bit above the buffer range means the access is out of bounds.
    assign w_oob          = |issue_rs2_i[XLEN-1:IDXW];
    assign w_prod         = issue_rs1_i * r_dense[w_idx];

    assign result_valid_o = r_res_valid;
    assign result_id_o    = r_res_id;
    assign result_rd_o    = r_res_rd;
    assign result_data_o  = r_res_data;
    assign mac_count_o    = r_mac_count;
    assign oob_err_o      = r_oob;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: only LOAD_SPARSE and STORE_ACC leave IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (issue_op_i == OP_LOAD_SPARSE)) begin
                    w_next_state = S_MUL;
                end else if (w_accept && (issue_op_i == OP_STORE_ACC)) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MUL:  w_next_state = S_ACC;
            S_ACC:  w_next_state = S_IDLE;
            S_RESP: begin
                if (result_ready_i) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Dense buffer, MAC datapath, sticky error and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DENSE_DEPTH; i++) begin
                r_dense[i] <= {XLEN{1'b0}};
            end
            r_acc       <= {XLEN{1'b0}};
            r_prod      <= {XLEN{1'b0}};
            r_prod_live <= 1'b0;
            r_mac_count <= {CNT_WIDTH{1'b0}};
            r_oob       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= {ID_WIDTH{1'b0}};
            r_res_rd    <= 5'd0;
            r_res_data  <= {XLEN{1'b0}};
        end else begin
            if (w_accept) begin
                case (issue_op_i)
                    OP_LOAD_DENSE: begin
                        if (w_oob) begin
                            r_oob <= 1'b1;
                        end else begin
                            r_dense[w_idx] <= issue_rs1_i;
                        end
                    end
                    OP_LOAD_SPARSE: begin
                        // An out-of-range op still walks MUL/ACC but adds zero and is not counted.
                        r_prod      <= w_oob ? {XLEN{1'b0}} : w_prod;
                        r_prod_live <= ~w_oob;
                        if (w_oob) begin
                            r_oob <= 1'b1;
                        end
                    end
                    OP_RESET_ACC: begin
                        r_acc       <= {XLEN{1'b0}};
                        r_mac_count <= {CNT_WIDTH{1'b0}};
                        r_oob       <= 1'b0;
                    end
                    OP_STORE_ACC: begin
                        r_res_valid <= 1'b1;
                        r_res_id    <= issue_id_i;
                        r_res_rd    <= issue_rd_i;
                        r_res_data  <= r_acc;
                    end
                    default: begin
                        r_oob <= r_oob;
                    end
                endcase
            end
            if (r_state == S_MUL) begin
                r_acc <= r_acc + r_prod;
                if (r_prod_live) begin
                    r_mac_count <= sat_inc(r_mac_count);
                end
            end
            if ((r_state == S_RESP) && result_ready_i) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule
